// File: rtl/adc_scan_avg.sv
// adc_scan_avg: round-robin ADC channel scanner, frame-synchronised to the serial interface,
// discarding stale post-switch frames and averaging 2**AVG_LOG2 samples per channel.
module adc_scan_avg #(
    parameter int NUM_CH       = 8,
    parameter int AVG_LOG2     = 2,
    parameter int DISCARD      = 1,
    parameter int FRAME_LEN    = 16,
    parameter int SAMPLE_PHASE = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scan_en,
    input  logic [11:0] adc_result,
    output logic [2:0]  adc_chan,
    output logic [11:0] avg_data,
    output logic [2:0]  avg_ch,
    output logic        avg_valid,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic        busy
);
    localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int AW = 12 + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam logic [FW-1:0] F_LAST = FW'(FRAME_LEN - 1);
    localparam logic [FW-1:0] F_TICK = FW'(SAMPLE_PHASE);
    localparam logic [SW-1:0] S_LAST = SW'((1 << AVG_LOG2) - 1);
    localparam logic [1:0]    D_LAST = 2'(DISCARD - 1);
    localparam logic [2:0]    C_LAST = 3'(NUM_CH - 1);
    localparam logic [3:0]    C_NUM  = 4'(NUM_CH);

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM} state_t;

    state_t          state, state_nx;
    logic [FW-1:0]   frame_cnt;
    logic [1:0]      disc_cnt;
    logic [SW-1:0]   smp_cnt;
    logic [AW-1:0]   acc, acc_sum;
    logic [11:0]     avg_val;
    logic [11:0]     regfile [8];
    logic            tick, start, disc_done, smp_done;

    assign tick      = frame_cnt == F_TICK;
    assign acc_sum   = acc + AW'(adc_result);
    assign avg_val   = 12'(acc_sum >> AVG_LOG2);
    assign start     = state == IDLE && tick && scan_en;
    assign disc_done = state == SETTLE && tick && disc_cnt == D_LAST;
    assign smp_done  = state == ACCUM && tick && smp_cnt == S_LAST;

    // Free-running mirror of the interface's frame counter; must stay in lockstep with it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_cnt <= '0;
        else
            frame_cnt <= (frame_cnt == F_LAST) ? '0 : frame_cnt + FW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = start     ? SETTLE :
                   disc_done ? ACCUM  :
                   smp_done  ? (scan_en ? SETTLE : IDLE) :
                   state;
    end

    always_comb begin
        busy = state != IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            adc_chan  <= '0;
            disc_cnt  <= '0;
            smp_cnt   <= '0;
            acc       <= '0;
            avg_data  <= '0;
            avg_ch    <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= smp_done;
            if (start) begin
                adc_chan <= '0;
                disc_cnt <= '0;
                smp_cnt  <= '0;
                acc      <= '0;
            end
            if (state == SETTLE && tick)
                disc_cnt <= disc_cnt + 2'd1;
            if (state == ACCUM && tick) begin
                acc     <= smp_done ? '0 : acc_sum;
                smp_cnt <= smp_done ? '0 : smp_cnt + SW'(1);
            end
            // Channel only advances on the completing tick, so chan never moves mid-frame.
            if (smp_done) begin
                avg_data <= avg_val;
                avg_ch   <= adc_chan;
                disc_cnt <= '0;
                if (scan_en)
                    adc_chan <= (adc_chan == C_LAST) ? '0 : adc_chan + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++)
                regfile[i] <= '0;
        end else if (smp_done) begin
            regfile[adc_chan] <= avg_val;
        end
    end

    assign rd_data = ({1'b0, rd_ch} < C_NUM) ? regfile[rd_ch] : '0;

endmodule

// File: tb/tb_adc_scan_avg.sv
// tb_adc_scan_avg: directed scoreboard bench for adc_scan_avg (default and NUM_CH=4 instances).
module tb_adc_scan_avg;
    logic        clk = 1'b0;
    logic        reset_n, scan_en;
    logic [11:0] adc_result;
    logic [2:0]  adc_chan, avg_ch, rd_ch;
    logic [11:0] avg_data, rd_data;
    logic        avg_valid, busy;
    logic [2:0]  adc_chan4, avg_ch4, rd_ch4;
    logic [11:0] avg_data4, rd_data4;
    logic        avg_valid4, busy4;

    typedef struct {
        logic [2:0]  ch;
        logic [11:0] d;
        int          c;
    } exp_t;

    exp_t        q[$];
    exp_t        me;
    int          cyc;
    int          next_cyc;
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  prev_chan;
    logic [11:0] rb [8];

    adc_scan_avg u_dut (
        .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .adc_result(adc_result),
        .adc_chan(adc_chan), .avg_data(avg_data), .avg_ch(avg_ch), .avg_valid(avg_valid),
        .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy)
    );

    adc_scan_avg #(.NUM_CH(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .adc_result(adc_result),
        .adc_chan(adc_chan4), .avg_data(avg_data4), .avg_ch(avg_ch4), .avg_valid(avg_valid4),
        .rd_ch(rd_ch4), .rd_data(rd_data4), .busy(busy4)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cyc <= 0;
        else
            cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick();
        while (cyc % 16 != 0) @(negedge clk);
    endtask

    task automatic tk(input logic [11:0] v, input logic en);
        wait_tick();
        adc_result = v;
        scan_en = en;
        @(negedge clk);
    endtask

    task automatic push(input logic [2:0] c, input logic [11:0] d);
        q.push_back('{ch: c, d: d, c: next_cyc});
        next_cyc += 80;
    endtask

    task automatic chan(input logic [2:0] c, input logic en, input logic [11:0] d,
                        input logic [11:0] a, input logic [11:0] b,
                        input logic [11:0] e, input logic [11:0] f);
        logic [13:0] s;
        s = 14'(a) + 14'(b) + 14'(e) + 14'(f);
        tk(d, 1'b1);
        tk(a, 1'b1);
        tk(b, 1'b1);
        tk(e, en);
        push(c, s[13:2]);
        tk(f, en);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        scan_en = 1'b0;
        adc_result = '0;
        rd_ch = '0;
        rd_ch4 = '0;
        prev_chan = '0;
        fork
            forever begin
                @(negedge clk);
                if (reset_n && avg_valid) begin
                    checks++;
                    assert (q.size() != 0) else begin
                        errors++;
                        $error("FAIL unexpected_strobe obs=ch%0d/%0h exp=none", avg_ch, avg_data);
                    end
                    if (q.size() != 0) begin
                        me = q.pop_front();
                        checks++;
                        assert ({avg_ch, avg_data} === {me.ch, me.d}) else begin
                            errors++;
                            $error("FAIL avg obs=ch%0d/%0h exp=ch%0d/%0h", avg_ch, avg_data, me.ch, me.d);
                        end
                        checks++;
                        assert (cyc === me.c) else begin
                            errors++;
                            $error("FAIL strobe_cycle ch%0d obs=%0d exp=%0d", me.ch, cyc, me.c);
                        end
                    end
                end
                if (reset_n && adc_chan !== prev_chan) begin
                    checks++;
                    assert (cyc % 16 == 1) else begin
                        errors++;
                        $error("FAIL chan_off_tick obs=%0d exp=1", cyc % 16);
                    end
                end
                prev_chan = adc_chan;
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_avg_data", 32'(avg_data), 32'h0);
        chk("rst_avg_ch", 32'(avg_ch), 32'h0);
        chk("rst_avg_valid", 32'(avg_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_adc_chan", 32'(adc_chan), 32'h0);
        chk("rst_rd_data", 32'(rd_data), 32'h0);
        reset_n = 1'b1;

        // Constant input, full scan with wrap back to ch0
        next_cyc = cyc + 81;
        tk(12'h800, 1'b1);
        chk("start_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 9; k++)
            chan(3'(k % 8), 1'b1, 12'h800, 12'h800, 12'h800, 12'h800, 12'h800);
        drain();
        chk("wrap_adc_chan", 32'(adc_chan), 32'h1);
        rd_ch = 3'd7;
        rd_ch4 = 3'd7;
        #1;
        chk("rd7_ch8", 32'(rd_data), 32'h800);
        chk("rd7_ch4_oor", 32'(rd_data4), 32'h0);
        rd_ch4 = 3'd3;
        #1;
        chk("rd3_ch4", 32'(rd_data4), 32'h800);
        chk("ch4_adc_chan", 32'(adc_chan4), 32'h1);
        @(negedge clk);

        // Averaging arithmetic and same-cycle read-before-write on ch1
        tk(12'hFFF, 1'b1);
        tk(12'h001, 1'b1);
        tk(12'h002, 1'b1);
        tk(12'h003, 1'b1);
        push(3'd1, 12'h003);
        rd_ch = 3'd1;
        wait_tick();
        chk("rf_old_on_write", 32'(rd_data), 32'h800);
        adc_result = 12'h006;
        @(negedge clk);
        chk("rf_new_after_write", 32'(rd_data), 32'h003);
        chan(3'd2, 1'b1, 12'h5A5, 12'h001, 12'h001, 12'h001, 12'h002);
        chan(3'd3, 1'b1, 12'hFFF, 12'h000, 12'h000, 12'h000, 12'h000);
        chan(3'd4, 1'b1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF);
        chan(3'd5, 1'b1, 12'h000, 12'h100, 12'h100, 12'h100, 12'h103);
        chan(3'd6, 1'b1, 12'h000, 12'h555, 12'h555, 12'h555, 12'h555);
        chan(3'd7, 1'b1, 12'h000, 12'h7A0, 12'h7A0, 12'h7A0, 12'h7A0);
        chan(3'd0, 1'b1, 12'h000, 12'h0AB, 12'h0AB, 12'h0AB, 12'h0AB);
        drain();
        rb = '{12'h0AB, 12'h003, 12'h001, 12'h000, 12'hFFF, 12'h100, 12'h555, 12'h7A0};
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            chk($sformatf("readback_ch%0d", i), 32'(rd_data), 32'(rb[i]));
        end
        @(negedge clk);

        // Stop request during ch3 accumulation
        chan(3'd1, 1'b1, 12'h000, 12'h111, 12'h111, 12'h111, 12'h111);
        chan(3'd2, 1'b1, 12'h000, 12'h222, 12'h222, 12'h222, 12'h222);
        chan(3'd3, 1'b0, 12'h000, 12'h333, 12'h333, 12'h333, 12'h333);
        drain();
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_adc_chan", 32'(adc_chan), 32'h3);
        repeat (6) tk(12'h444, 1'b0);
        chk("idle_adc_chan", 32'(adc_chan), 32'h3);
        chk("idle_busy", 32'(busy), 32'h0);
        drain();

        // Restart, then reset in the middle of ch5 accumulation
        wait_tick();
        next_cyc = cyc + 81;
        tk(12'h000, 1'b1);
        chk("restart_adc_chan", 32'(adc_chan), 32'h0);
        for (int k = 0; k < 5; k++)
            chan(3'(k), 1'b1, 12'hFFF, 12'(16 * (k + 1)), 12'(16 * (k + 1)), 12'(16 * (k + 1)), 12'(16 * (k + 1)));
        tk(12'h000, 1'b1);
        tk(12'h200, 1'b1);
        tk(12'h200, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        chk("pre_rst_adc_chan", 32'(adc_chan), 32'h5);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_avg_data", 32'(avg_data), 32'h0);
        chk("mid_rst_avg_ch", 32'(avg_ch), 32'h0);
        chk("mid_rst_avg_valid", 32'(avg_valid), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_adc_chan", 32'(adc_chan), 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd_ch = 3'(i);
            #1;
            chk($sformatf("mid_rst_rf%0d", i), 32'(rd_data), 32'h0);
        end
        scan_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) tk(12'h300, 1'b0);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_adc_chan", 32'(adc_chan), 32'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
